// File: rtl/tick_ctrl_pkg.sv
// Shared encodings for the run/halt/step tick controller.
package tick_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_STEP = 2'b10
  } mode_t;

  localparam int STEP_CNT_W = 8;

endpackage

// File: rtl/tick_period_core.sv
// Programmable period down-counter: flags the cycle on which a tick is due
// and reloads itself from the supplied period.
module tick_period_core #(
  parameter int NrOfBits = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                load_full,
  input  logic                load_zero,
  input  logic [NrOfBits-1:0] reload,
  output logic                tick_next
);

  localparam logic [NrOfBits-1:0] ONE = NrOfBits'(1);

  logic [NrOfBits-1:0] count;

  assign tick_next = enable && (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load_full) begin
      count <= reload - ONE;
    end else if (load_zero) begin
      count <= '0;
    end else if (enable) begin
      count <= tick_next ? (reload - ONE) : (count - ONE);
    end
  end

endmodule

// File: rtl/tick_run_controller.sv
// Run/halt/single-step sequencer for the CPU clock-enable tick.
// Optional tick counter enabled by defining TICK_RUN_CTRL_TICK_COUNT_EN.
module tick_run_controller
  import tick_ctrl_pkg::*;
#(
  parameter int NrOfBits      = 24,
  parameter int DefaultReload = 12500000,
  parameter int StepTicks     = 1,
  parameter int StartRunning  = 0
) (
  input  logic                FPGAClock,
  input  logic                FPGAReset,
  input  logic [NrOfBits-1:0] cfg_reload,
  input  logic                cfg_load,
  input  logic                cmd_run,
  input  logic                cmd_halt,
  input  logic                cmd_step,
  input  logic                halt_req,
  output logic                FPGATick,
  output logic [1:0]          mode,
  output logic                step_done,
  output logic [31:0]         tick_count
);

  localparam logic [NrOfBits-1:0]   ONE            = NrOfBits'(1);
  localparam logic [NrOfBits-1:0]   DEFAULT_RELOAD = NrOfBits'(DefaultReload);
  localparam logic [STEP_CNT_W-1:0] STEP_INIT      = STEP_CNT_W'(StepTicks);
  localparam logic [STEP_CNT_W-1:0] STEP_ONE       = STEP_CNT_W'(1);
  localparam mode_t                 RESET_MODE     = (StartRunning != 0) ? MODE_RUN : MODE_HALT;

  // A zero period would never tick; treat it as the fastest legal period.
  function automatic logic [NrOfBits-1:0] clamp_reload(input logic [NrOfBits-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

  mode_t                 state;
  logic [STEP_CNT_W-1:0] remaining;
  logic [NrOfBits-1:0]   active_reload;
  logic                  halt_now;
  logic                  enable;
  logic                  start_run;
  logic                  start_step;
  logic                  last_step;
  logic                  tick_next;

  assign halt_now   = halt_req || cmd_halt;
  assign enable     = (state != MODE_HALT) && !halt_now;
  assign start_run  = (state == MODE_HALT) && !halt_now && cmd_run;
  assign start_step = (state == MODE_HALT) && !halt_now && !cmd_run && cmd_step;
  // cmd_run during STEP hands over to RUN, so that tick does not finish the step.
  assign last_step  = (state == MODE_STEP) && tick_next && !cmd_run && (remaining == STEP_ONE);

  tick_period_core #(
    .NrOfBits (NrOfBits)
  ) u_core (
    .clk       (FPGAClock),
    .rst       (FPGAReset),
    .enable    (enable),
    .load_full (start_run),
    .load_zero (start_step),
    .reload    (active_reload),
    .tick_next (tick_next)
  );

  always_ff @(posedge FPGAClock) begin
    if (FPGAReset) begin
      state         <= RESET_MODE;
      remaining     <= '0;
      active_reload <= DEFAULT_RELOAD;
      FPGATick      <= 1'b0;
      step_done     <= 1'b0;
    end else begin
      FPGATick  <= tick_next;
      step_done <= last_step;
      if (cfg_load) begin
        active_reload <= clamp_reload(cfg_reload);
      end
      case (state)
        MODE_HALT: begin
          if (start_run) begin
            state <= MODE_RUN;
          end else if (start_step) begin
            state     <= MODE_STEP;
            remaining <= STEP_INIT;
          end
        end
        MODE_RUN: begin
          if (halt_now) begin
            state <= MODE_HALT;
          end
        end
        MODE_STEP: begin
          if (halt_now) begin
            state <= MODE_HALT;
          end else if (cmd_run) begin
            state <= MODE_RUN;
          end else if (tick_next) begin
            remaining <= remaining - STEP_ONE;
            if (remaining == STEP_ONE) begin
              state <= MODE_HALT;
            end
          end
        end
        default: state <= MODE_HALT;
      endcase
    end
  end

  assign mode = state;

`ifdef TICK_RUN_CTRL_TICK_COUNT_EN
  always_ff @(posedge FPGAClock) begin
    if (FPGAReset) begin
      tick_count <= '0;
    end else if (FPGATick) begin
      tick_count <= tick_count + 32'd1;
    end
  end
`else
  assign tick_count = 32'd0;
`endif

endmodule
